// File: rtl/rmio_seq.sv
// Sequencer between the RF RAM and one execution unit: loads operand slots
// from RAM into the EU, starts it, waits for completion, then stores results.
module rmio_seq #(
   parameter int INPUT_NUM  = 1,
   parameter int OUTPUT_NUM = 1,
   parameter int DATA_W     = 1408,
   parameter int ADDR_W     = 8,
   parameter int IC_W       = $clog2(INPUT_NUM + 1),
   parameter int OC_W       = $clog2(OUTPUT_NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_W-1:0]     cmd_in_base,
   input  logic [IC_W-1:0]       cmd_in_cnt,
   input  logic [ADDR_W-1:0]     cmd_out_base,
   input  logic [OC_W-1:0]       cmd_out_cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_re,
   output logic [ADDR_W-1:0]     ram_raddr,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_waddr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic [DATA_W-1:0]     eu_input_data,
   output logic [0:INPUT_NUM-1]  eu_input_we,
   output logic [0:OUTPUT_NUM-1] eu_output_re,
   input  logic [DATA_W-1:0]     eu_output_data,
   output logic                  eu_start,
   input  logic                  eu_done
);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, WAIT, STORE, FLUSH, DONE} state_e;

   state_e                state_q;
   logic                  cmd_ready_q, busy_q, done_q, eu_start_q;
   logic                  ram_re_q, ram_we_q;
   logic [ADDR_W-1:0]     ram_raddr_q, ram_waddr_q, out_base_q;
   logic [IC_W-1:0]       in_n_q, rd_idx_q, p_slot_q;
   logic [OC_W-1:0]       out_n_q, wr_idx_q;
   logic                  p_vld_q;
   logic [DATA_W-1:0]     eu_input_data_q;
   logic [0:INPUT_NUM-1]  eu_input_we_q;
   logic [0:OUTPUT_NUM-1] eu_output_re_q;
   logic [IC_W-1:0]       in_n_d;
   logic [OC_W-1:0]       out_n_d;

   function automatic logic [0:INPUT_NUM-1] in_oh(input logic [IC_W-1:0] slot);
      in_oh = '0;
      for (int k = 0; k < INPUT_NUM; k++) in_oh[k] = (int'(slot) == k);
   endfunction

   function automatic logic [0:OUTPUT_NUM-1] out_oh(input logic [OC_W-1:0] slot);
      out_oh = '0;
      for (int k = 0; k < OUTPUT_NUM; k++) out_oh[k] = (int'(slot) == k);
   endfunction

   always_comb begin
      in_n_d  = (cmd_in_cnt > IC_W'(INPUT_NUM)) ? IC_W'(INPUT_NUM) : cmd_in_cnt;
      out_n_d = (cmd_out_cnt > OC_W'(OUTPUT_NUM)) ? OC_W'(OUTPUT_NUM) : cmd_out_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cmd_ready_q     <= 1'b1;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         eu_start_q      <= 1'b0;
         ram_re_q        <= 1'b0;
         ram_we_q        <= 1'b0;
         ram_raddr_q     <= '0;
         ram_waddr_q     <= '0;
         out_base_q      <= '0;
         in_n_q          <= '0;
         out_n_q         <= '0;
         rd_idx_q        <= '0;
         wr_idx_q        <= '0;
         p_vld_q         <= 1'b0;
         p_slot_q        <= '0;
         eu_input_data_q <= '0;
         eu_input_we_q   <= '0;
         eu_output_re_q  <= '0;
      end else begin
         // Read return pipeline: RAM data lands one cycle after ram_re and is
         // re-registered onto the EU operand bus with its slot strobe.
         p_vld_q       <= ram_re_q;
         p_slot_q      <= rd_idx_q;
         eu_input_we_q <= '0;
         if (p_vld_q) begin
            eu_input_we_q   <= in_oh(p_slot_q);
            eu_input_data_q <= ram_rdata;
         end

         case (state_q)
            IDLE: if (cmd_valid) begin
               in_n_q      <= in_n_d;
               out_n_q     <= out_n_d;
               out_base_q  <= cmd_out_base;
               ram_raddr_q <= cmd_in_base;
               rd_idx_q    <= '0;
               cmd_ready_q <= 1'b0;
               busy_q      <= 1'b1;
               if (in_n_d != '0) begin
                  ram_re_q <= 1'b1;
                  state_q  <= LOAD;
               end else begin
                  eu_start_q <= 1'b1;
                  state_q    <= START;
               end
            end
            LOAD: begin
               if (rd_idx_q == in_n_q - IC_W'(1)) begin
                  ram_re_q <= 1'b0;
                  state_q  <= DRAIN;
               end else begin
                  rd_idx_q    <= rd_idx_q + IC_W'(1);
                  ram_raddr_q <= ram_raddr_q + ADDR_W'(1);
               end
            end
            // Last read is still returning while p_vld_q is high; start once it has left.
            DRAIN: if (!p_vld_q) begin
               eu_start_q <= 1'b1;
               state_q    <= START;
            end
            START: begin
               eu_start_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: if (eu_done) begin
               if (out_n_q != '0) begin
                  eu_output_re_q <= out_oh(OC_W'(0));
                  wr_idx_q       <= '0;
                  state_q        <= STORE;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            STORE: begin
               ram_we_q    <= 1'b1;
               ram_waddr_q <= out_base_q + ADDR_W'(wr_idx_q);
               if (wr_idx_q == out_n_q - OC_W'(1)) begin
                  eu_output_re_q <= '0;
                  state_q        <= FLUSH;
               end else begin
                  wr_idx_q       <= wr_idx_q + OC_W'(1);
                  eu_output_re_q <= out_oh(wr_idx_q + OC_W'(1));
               end
            end
            FLUSH: begin
               ram_we_q <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign eu_start      = eu_start_q;
   assign ram_re        = ram_re_q;
   assign ram_raddr     = ram_raddr_q;
   assign ram_we        = ram_we_q;
   assign ram_waddr     = ram_waddr_q;
   // EU result arrives in the write cycle itself, so it passes straight through.
   assign ram_wdata     = ram_we_q ? eu_output_data : '0;
   assign eu_input_data = eu_input_data_q;
   assign eu_input_we   = eu_input_we_q;
   assign eu_output_re  = eu_output_re_q;

endmodule

// File: tb/tb_rmio_seq.sv
// Randomised bench for rmio_seq: a cycle-schedule model derived from the
// command counts predicts every strobe, address and data word.
module tb_rmio_seq;

   localparam int IN  = 4;
   localparam int ON  = 2;
   localparam int DW  = 64;
   localparam int AW  = 8;
   localparam int ICW = 3;
   localparam int OCW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           cmd_valid, cmd_ready;
   logic [AW-1:0]  cmd_in_base, cmd_out_base;
   logic [ICW-1:0] cmd_in_cnt;
   logic [OCW-1:0] cmd_out_cnt;
   logic           busy, done, ram_re, ram_we, eu_start, eu_done;
   logic [AW-1:0]  ram_raddr, ram_waddr;
   logic [DW-1:0]  ram_rdata, ram_wdata, eu_input_data, eu_output_data;
   logic [0:IN-1]  eu_input_we;
   logic [0:ON-1]  eu_output_re;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] res [ON];
   logic [DW-1:0] hold_data;

   always #5 clk = ~clk;

   rmio_seq #(.INPUT_NUM(IN), .OUTPUT_NUM(ON), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_in_base(cmd_in_base), .cmd_in_cnt(cmd_in_cnt),
      .cmd_out_base(cmd_out_base), .cmd_out_cnt(cmd_out_cnt),
      .busy(busy), .done(done),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .eu_input_data(eu_input_data), .eu_input_we(eu_input_we),
      .eu_output_re(eu_output_re), .eu_output_data(eu_output_data),
      .eu_start(eu_start), .eu_done(eu_done)
   );

   function automatic logic [DW-1:0] junk();
      return {$urandom, $urandom};
   endfunction

   // Runs one command from its acceptance cycle (0) through the first idle cycle
   // after done, checking every output each cycle against the expected schedule.
   task automatic run_cmd(input logic [7:0] ib, input int ic, input logic [7:0] ob, input int oc,
                          input int dly, input bit early, input int spur_in, input bit b2b,
                          input logic [7:0] nib, input int nic, input logic [7:0] nob, input int noc);
      int n, m, s, d, dc, spur;
      logic prev_re;
      logic [7:0] prev_ra, exp_ra, exp_wa;
      logic [0:ON-1] prev_ore, exp_ore;
      logic [0:IN-1] exp_we;
      logic exp_re, exp_wr;
      logic [DW-1:0] exp_wd;
      n  = (ic > IN) ? IN : ic;
      m  = (oc > ON) ? ON : oc;
      s  = (n == 0) ? 1 : n + 3;
      d  = early ? s + 1 : s + 1 + dly;
      dc = (m == 0) ? d + 1 : d + m + 2;
      spur = (spur_in > s) ? -1 : spur_in;
      for (int k = 0; k < ON; k++) res[k] = junk();
      cmd_in_base  = ib;
      cmd_in_cnt   = ICW'(ic);
      cmd_out_base = ob;
      cmd_out_cnt  = OCW'(oc);
      cmd_valid    = 1'b1;
      eu_done      = early || (spur == 0);
      ram_rdata      = junk();
      eu_output_data = junk();
      prev_re  = 1'b0;
      prev_ra  = '0;
      prev_ore = '0;
      for (int c = 1; c <= dc + 1; c++) begin
         @(posedge clk); #1;
         ram_rdata = prev_re ? mem[prev_ra] : junk();
         eu_output_data = junk();
         for (int k = 0; k < ON; k++) if (prev_ore[k]) eu_output_data = res[k];
         eu_done = early ? (c <= d) : (c == d || c == spur);
         if (c == 1) begin
            if (b2b) begin
               cmd_in_base = nib; cmd_in_cnt = ICW'(nic);
               cmd_out_base = nob; cmd_out_cnt = OCW'(noc);
            end else begin
               cmd_valid = 1'b0;
               cmd_in_base = 8'($urandom); cmd_in_cnt = ICW'($urandom);
               cmd_out_base = 8'($urandom); cmd_out_cnt = OCW'($urandom);
            end
         end
         #1;
         exp_re = (n > 0 && c <= n);
         exp_ra = ib + 8'(c - 1);
         exp_we = '0;
         if (n > 0 && c >= 3 && c <= n + 2) begin
            exp_we[c - 3] = 1'b1;
            hold_data = mem[ib + 8'(c - 3)];
         end
         exp_ore = '0;
         if (c >= d + 1 && c <= d + m) exp_ore[c - d - 1] = 1'b1;
         exp_wr = (c >= d + 2 && c <= d + m + 1);
         exp_wa = ob + 8'(c - d - 2);
         exp_wd = exp_wr ? res[c - d - 2] : '0;

         total++;
         if (ram_re !== exp_re || (exp_re && ram_raddr !== exp_ra)) begin
            bad++;
            $display("FAIL rd c=%0d: got re=%b addr=%h, want re=%b addr=%h", c, ram_re, ram_raddr, exp_re, exp_ra);
         end
         total++;
         if (eu_input_we !== exp_we || eu_input_data !== hold_data) begin
            bad++;
            $display("FAIL in_bus c=%0d: got we=%b data=%h, want we=%b data=%h", c, eu_input_we, eu_input_data, exp_we, hold_data);
         end
         total++;
         if (eu_start !== (c == s)) begin
            bad++;
            $display("FAIL start c=%0d: got %b, want %b", c, eu_start, (c == s));
         end
         total++;
         if (eu_output_re !== exp_ore) begin
            bad++;
            $display("FAIL out_re c=%0d: got %b, want %b", c, eu_output_re, exp_ore);
         end
         total++;
         if (ram_we !== exp_wr || (exp_wr && (ram_waddr !== exp_wa || ram_wdata !== exp_wd))) begin
            bad++;
            $display("FAIL wr c=%0d: got we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                     c, ram_we, ram_waddr, ram_wdata, exp_wr, exp_wa, exp_wd);
         end
         total++;
         if (done !== (c == dc)) begin
            bad++;
            $display("FAIL done c=%0d: got %b, want %b", c, done, (c == dc));
         end
         total++;
         if (busy !== (c <= dc) || cmd_ready !== (c > dc)) begin
            bad++;
            $display("FAIL busy_rdy c=%0d: got busy=%b rdy=%b, want busy=%b rdy=%b", c, busy, cmd_ready, (c <= dc), (c > dc));
         end
         prev_re  = ram_re;
         prev_ra  = ram_raddr;
         prev_ore = eu_output_re;
      end
      eu_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b1; cmd_in_base = 8'h11; cmd_in_cnt = 3'd2;
      cmd_out_base = 8'h22; cmd_out_cnt = 2'd1;
      eu_done = 1'b1; ram_rdata = junk(); eu_output_data = junk();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re,
           ram_raddr, ram_waddr, ram_wdata, eu_input_data} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got re=%b we=%b st=%b dn=%b busy=%b iwe=%b ore=%b ra=%h wa=%h wd=%h id=%h, want all 0",
                  ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re, ram_raddr, ram_waddr, ram_wdata, eu_input_data);
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b, want 1", cmd_ready);
      end
      rst = 1'b0; cmd_valid = 1'b0; eu_done = 1'b0;
      hold_data = '0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle_after_reset: got busy=%b rdy=%b, want busy=0 rdy=1", busy, cmd_ready);
      end
   endtask

   task automatic test_basic();
      run_cmd(8'h10, 3, 8'h40, 2, 3, 1'b0, -1, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_zero_counts();
      run_cmd(8'h20, 0, 8'h50, 0, 2, 1'b0, -1, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_wrap_clamp();
      run_cmd(8'hFE, 7, 8'hFF, 3, 1, 1'b0, -1, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_early_done();
      run_cmd(8'h30, 2, 8'h60, 1, 0, 1'b1, -1, 1'b0, 8'h0, 0, 8'h0, 0);
      run_cmd(8'h38, 0, 8'h68, 2, 0, 1'b1, -1, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_back_to_back();
      run_cmd(8'h05, 4, 8'h80, 2, 0, 1'b0, -1, 1'b1, 8'h90, 1, 8'h10, 1);
      run_cmd(8'h90, 1, 8'h10, 1, 4, 1'b0, 2, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_reset_abort();
      cmd_in_base = 8'h70; cmd_in_cnt = 3'd4; cmd_out_base = 8'hA0; cmd_out_cnt = 2'd2;
      cmd_valid = 1'b1; eu_done = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ram_re !== 1'b1 || ram_raddr !== 8'h71) begin
         bad++;
         $display("FAIL abort_pre: got re=%b addr=%h, want re=1 addr=71", ram_re, ram_raddr);
      end
      rst = 1'b1;
      ram_rdata = mem[8'h70];
      @(posedge clk); #1;
      rst = 1'b0;
      hold_data = '0;
      total++;
      if ({ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re} !== '0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort_now: got re=%b we=%b st=%b dn=%b busy=%b iwe=%b ore=%b rdy=%b, want strobes/busy 0 rdy 1",
                  ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re, cmd_ready);
      end
      for (int c = 0; c < 8; c++) begin
         ram_rdata = junk(); eu_done = 1'($urandom);
         @(posedge clk); #1;
         total++;
         if ({ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re} !== '0 ||
             cmd_ready !== 1'b1 || eu_input_data !== '0) begin
            bad++;
            $display("FAIL abort_quiet c=%0d: got re=%b we=%b st=%b dn=%b busy=%b iwe=%b ore=%b rdy=%b id=%h, want idle",
                     c, ram_re, ram_we, eu_start, done, busy, eu_input_we, eu_output_re, cmd_ready, eu_input_data);
         end
      end
      eu_done = 1'b0;
      run_cmd(8'h70, 4, 8'hA0, 2, 1, 1'b0, -1, 1'b0, 8'h0, 0, 8'h0, 0);
   endtask

   task automatic test_random();
      logic [7:0] ib, ob, nib, nob;
      int ic, oc, nic, noc;
      bit b2b;
      ib = 8'($urandom); ic = $urandom_range(0, 7);
      ob = 8'($urandom); oc = $urandom_range(0, 3);
      for (int i = 0; i < 24; i++) begin
         nib = 8'($urandom); nic = $urandom_range(0, 7);
         nob = 8'($urandom); noc = $urandom_range(0, 3);
         b2b = (i < 23) && ($urandom_range(0, 1) == 1);
         run_cmd(ib, ic, ob, oc, $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1, b2b, nib, nic, nob, noc);
         ib = nib; ic = nic; ob = nob; oc = noc;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = junk();
      hold_data = '0;
      test_reset();
      test_basic();
      test_zero_counts();
      test_wrap_clamp();
      test_early_done();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end, want completion");
      $fatal(1);
   end

endmodule

// File: doc/rmio_seq.md
Name: rmio_seq

Overview:
- Parametrised RF-RAM-to-execution-unit sequencer.
- On each command it streams up to INPUT_NUM operand slots from the RF RAM into the EU, with a per-slot write enable, then starts the EU and waits for completion.
- It then drains up to OUTPUT_NUM result slots from the EU back into the RF RAM.
- Sits between the RF RAM and one EU. It generalises the plain RF/EU operand bus with command-driven counts, base addressing, pipelined transfers and an EU start/done handshake.

Parameters:
- INPUT_NUM, 1, number of EU input slots.
- OUTPUT_NUM, 1, number of EU output slots.
- DATA_W, 1408, slot width in bits; equals the RAM word width.
- ADDR_W, 8, RF RAM word address width.
- IC_W, $clog2(INPUT_NUM+1), input count field width.
- OC_W, $clog2(OUTPUT_NUM+1), output count field width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_in_base  in  ADDR_W  RAM address of input slot 0
- cmd_in_cnt  in  IC_W  input slots to load
- cmd_out_base  in  ADDR_W  RAM address of output slot 0
- cmd_out_cnt  in  OC_W  output slots to store
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDR_W  read address
- ram_rdata  in  DATA_W  read data, valid 1 cycle after ram_re
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  write address
- ram_wdata  out  DATA_W  write data
- eu_input_data  out  DATA_W  operand bus (registered)
- eu_input_we  out  [0:INPUT_NUM-1]  one-hot slot write strobe
- eu_output_re  out  [0:OUTPUT_NUM-1]  one-hot slot read strobe
- eu_output_data  in  DATA_W  EU result, valid 1 cycle after eu_output_re
- eu_start  out  1  one-cycle EU start pulse
- eu_done  in  1  EU completion

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State goes to IDLE and counters clear. Reset mid-command aborts it with no done pulse and no further RAM or EU strobes.
- Command acceptance: on cmd_valid && cmd_ready (cycle 0), latch all cmd fields.
  - Counts above INPUT_NUM or OUTPUT_NUM are clamped to those values.
  - cmd_valid is ignored while busy.
- State sequence: IDLE -> LOAD -> DRAIN -> START -> WAIT -> STORE -> FLUSH -> DONE -> IDLE.
- LOAD (n = clamped input count), cycles 1..n:
  - ram_re=1 and ram_raddr = in_base + i for i = 0..n-1.
  - Address arithmetic is modulo 2^ADDR_W; wrap is allowed.
- Input path:
  - ram_rdata is captured into eu_input_data one cycle after it returns.
  - eu_input_we[i] pulses together with slot i's data, at cycle i+3.
  - eu_input_data holds its last value when no strobe is active.
- DRAIN: waits until the last eu_input_we has been emitted (cycle n+2).
- START: eu_start pulses at cycle n+3.
  - If n = 0, LOAD and DRAIN are skipped and eu_start pulses at cycle 1.
- WAIT:
  - eu_done is sampled only from the cycle after eu_start onward; an earlier or coincident eu_done is ignored.
  - eu_done seen at cycle d moves the FSM to STORE.
- STORE (m = clamped output count), cycles d+1..d+m: eu_output_re[j] one-hot for j = 0..m-1.
- Write-back: one cycle after each eu_output_re[j]:
  - ram_we = 1
  - ram_waddr = out_base + j (mod 2^ADDR_W)
  - ram_wdata = eu_output_data
- FLUSH: covers the final write at cycle d+m+1.
- DONE: done pulses at cycle d+m+2. busy is still high that cycle and drops the next cycle.
  - If m = 0, STORE and FLUSH are skipped and done pulses at d+1.
- cmd_ready returns to 1 the cycle after done. Back-to-back commands are allowed with no extra bubble.
- Strobe invariants:
  - At most one eu_input_we bit and one eu_output_re bit are high per cycle.
  - ram_re and ram_we never assert outside LOAD and STORE/FLUSH respectively.

Test Plan:
1. Basic transfer.
   - Stimulus: INPUT_NUM=4, OUTPUT_NUM=2, cmd in_base=0x10, in_cnt=3, out_base=0x40, out_cnt=2; EU raises eu_done at cycle 10.
   - Response: ram_re at cycles 1-3 with addresses 0x10-0x12; eu_input_we = 1000, 0100, 0010 at cycles 3-5 carrying RAM data; eu_start at 6; eu_output_re at 11-12; ram_we at 12-13 with addresses 0x40-0x41; done at 14.
2. Zero counts.
   - Stimulus: in_cnt=0, out_cnt=0.
   - Response: eu_start at cycle 1, no RAM access; done the cycle after eu_done.
3. Wrap and clamp.
   - Stimulus: ADDR_W=8, in_base=0xFE, in_cnt=7 with INPUT_NUM=4.
   - Response: 4 reads at addresses 0xFE, 0xFF, 0x00, 0x01.
4. Early done.
   - Stimulus: eu_done held high from cycle 0.
   - Response: ignored until the cycle after eu_start; STORE then begins the cycle after that.
5. Reset abort.
   - Stimulus: rst asserted during LOAD (cycle 2).
   - Response: next cycle all strobes are 0, busy=0, cmd_ready=1; no done pulse; a new command runs normally.
6. Back-to-back.
   - Stimulus: a second cmd_valid held through the first command.
   - Response: second command accepted the cycle after done; cmd_ready stays low throughout the first command.
